ddr_frame_streamer: RTL and testbench

- Reader counterpart to the camera capture path.
- Fetches a stored 320x240 frame from DDR, one pixel word per address, starting at a programmable offset, under the memory controller's pause handshake.
- Emits the frame as a raster pixel stream with valid/ready flow control, start-of-frame and end-of-line markers, through a small prefetch FIFO.
- Feeds downstream video output and image-processing blocks; sits beside the capture module on the same DDR port arbitration.

---
 rtl/ddr_frame_streamer.sv | 200 ++++++++++++++++++++
 tb/tb_ddr_frame_streamer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_streamer.sv
// Streams a stored raster frame out of DDR, one pixel word per address, through a prefetch FIFO.
// Optional macro READOUT_GRAYSCALE_EN replaces each pixel with replicated luma {Y,Y,Y}.
module ddr_frame_streamer #(
   parameter int FRAME_WIDTH  = 320,
   parameter int FRAME_HEIGHT = 240,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_WIDTH   = 20
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          readout_enable,
   output logic                          readout_done,
   input  logic [ADDR_WIDTH-1:0]         data_read_offset,
   output logic [ADDR_WIDTH-1:0]         ddr_addr,
   output logic                          ddr_rd_req,
   input  logic                          pause,
   input  logic [31:0]                   data_read,
   output logic [23:0]                   pixel_data,
   output logic                          pixel_valid,
   input  logic                          pixel_ready,
   output logic                          pixel_sof,
   output logic                          pixel_eol,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int LW    = PW + 1;
   localparam int XW    = $clog2(FRAME_WIDTH + 1);
   localparam int YW    = $clog2(FRAME_HEIGHT + 1);
   localparam int CW    = $clog2(TOTAL + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_STORE,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  req_q, req_d;
   logic [1:0]            wait_q, wait_d;
   logic [23:0]           pix_raw_q, pix_raw_d;
   logic [CW-1:0]         count_q, count_d;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic                  done_q, done_d;
   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]         level_q, level_d;
   logic [23:0]           mem_q [FIFO_DEPTH];
   logic [23:0]           push_pixel;
   logic                  push, pop, valid;
   logic                  unused_bits;

   assign unused_bits = ^data_read[23:16];

`ifdef READOUT_GRAYSCALE_EN
   logic [9:0] luma_sum;
   always_comb begin
      luma_sum   = 10'(pix_raw_q[7:0]) + {1'b0, pix_raw_q[15:8], 1'b0} + 10'(pix_raw_q[23:16]);
      push_pixel = {3{8'(luma_sum >> 2)}};
   end
`else
   assign push_pixel = pix_raw_q;
`endif

   assign valid = (level_q != '0);
   assign pop   = valid & pixel_ready;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_d   = state_q;
      base_d    = base_q;
      addr_d    = addr_q;
      req_d     = 1'b0;
      wait_d    = wait_q;
      pix_raw_d = pix_raw_q;
      count_d   = count_q;
      x_d       = x_q;
      y_d       = y_q;
      done_d    = done_q;
      push      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (readout_enable && !done_q) begin
               base_d  = data_read_offset;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // No read is in flight here, so the free-slot test only needs the FIFO level.
            if (level_q < LW'(FIFO_DEPTH)) begin
               req_d   = 1'b1;
               addr_d  = base_q + ADDR_WIDTH'(count_q);
               wait_d  = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_q == 2'd2 && !pause) begin
               pix_raw_d = {data_read[31:24], data_read[15:8], data_read[7:0]};
               state_d   = S_STORE;
            end else if (wait_q != 2'd2) begin
               wait_d = wait_q + 2'd1;
            end
         end
         S_STORE: begin
            push    = 1'b1;
            count_d = count_q + 1'b1;
            state_d = (count_q == CW'(TOTAL - 1)) ? S_DONE : S_REQ;
         end
         default: ;
      endcase

      if (pop) begin
         if (x_q == XW'(FRAME_WIDTH - 1)) begin
            x_d = '0;
            if (y_q == YW'(FRAME_HEIGHT - 1)) begin
               y_d    = '0;
               done_d = 1'b1;
            end else begin
               y_d = y_q + 1'b1;
            end
         end else begin
            x_d = x_q + 1'b1;
         end
      end

      wr_d    = push ? wr_q + 1'b1 : wr_q;
      rd_d    = pop  ? rd_q + 1'b1 : rd_q;
      level_d = level_q + LW'(push) - LW'(pop);

      // Dropping enable aborts the frame: flush, clear counters, ignore any late read data.
      if (!readout_enable) begin
         state_d = S_IDLE;
         req_d   = 1'b0;
         wait_d  = '0;
         count_d = '0;
         x_d     = '0;
         y_d     = '0;
         done_d  = 1'b0;
         push    = 1'b0;
         wr_d    = '0;
         rd_d    = '0;
         level_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!reset_n) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         addr_q    <= '0;
         req_q     <= 1'b0;
         wait_q    <= '0;
         pix_raw_q <= '0;
         count_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         done_q    <= 1'b0;
         wr_q      <= '0;
         rd_q      <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         wait_q    <= wait_d;
         pix_raw_q <= pix_raw_d;
         count_q   <= count_d;
         x_q       <= x_d;
         y_q       <= y_d;
         done_q    <= done_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         level_q   <= level_d;
      end
   end

   // NOTE: FIFO storage is not reset; pointers define occupancy and the output is gated by valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= push_pixel;
   end

   assign pixel_valid  = valid;
   assign pixel_data   = valid ? mem_q[rd_q] : '0;
   assign pixel_sof    = valid && (x_q == '0) && (y_q == '0);
   assign pixel_eol    = valid && (x_q == XW'(FRAME_WIDTH - 1));
   assign fifo_level   = level_q;
   assign ddr_addr     = addr_q;
   assign ddr_rd_req   = req_q;
   assign readout_done = done_q;

endmodule

// File: tb/tb_ddr_frame_streamer.sv
// Randomized bench for ddr_frame_streamer: a DDR controller model feeds reads, and a
// frame-level model (pixel i = memory word at offset+i) checks every output cycle.
module tb_ddr_frame_streamer;

   localparam int W     = 16;
   localparam int H     = 6;
   localparam int DEPTH = 8;
   localparam int AW    = 20;
   localparam int TOTAL = W * H;

   logic          clk = 1'b0;
   logic          reset_n, readout_enable, readout_done;
   logic [AW-1:0] data_read_offset, ddr_addr;
   logic          ddr_rd_req, pause;
   logic [31:0]   data_read;
   logic [23:0]   pixel_data;
   logic          pixel_valid, pixel_ready, pixel_sof, pixel_eol;
   logic [3:0]    fifo_level;

   always #5 clk = ~clk;

   ddr_frame_streamer #(
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .readout_enable(readout_enable),
      .readout_done(readout_done), .data_read_offset(data_read_offset),
      .ddr_addr(ddr_addr), .ddr_rd_req(ddr_rd_req), .pause(pause),
      .data_read(data_read), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready), .pixel_sof(pixel_sof), .pixel_eol(pixel_eol),
      .fifo_level(fifo_level)
   );

   int            errors = 0;
   int            checks = 0;
   logic [AW-1:0] frame_off;
   bit            model_on;
   int            ready_mode;
   int            fixed_delay;
   int            req_idx;
   int            out_idx;
   int            sof_cnt, eol_cnt;
   logic [AW-1:0] addr_log [TOTAL];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memval(input logic [AW-1:0] a);
      logic [31:0] h;
      if (a == 20'h00100) return 32'hAA553311;
      h = {12'h0, a} * 32'h9E3779B1;
      return h ^ 32'h5A5AC3C3;
   endfunction

   function automatic logic [23:0] conv(input logic [31:0] w);
`ifdef READOUT_GRAYSCALE_EN
      int y;
      y = (int'(w[7:0]) + 2 * int'(w[15:8]) + int'(w[31:24])) / 4;
      return {3{y[7:0]}};
`else
      return {w[31:24], w[15:8], w[7:0]};
`endif
   endfunction

   // DDR controller model and downstream ready generator, driven just after each rising edge.
   initial begin
      bit            pending = 1'b0;
      bit            addr_valid = 1'b0;
      int            k = 0;
      int            d = 2;
      logic [AW-1:0] lat_addr = '0;
      logic [AW-1:0] last_addr = '0;
      logic [AW-1:0] exp_addr;
      pause       = 1'b0;
      data_read   = '0;
      pixel_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       pixel_ready = 1'b1;
            1:       pixel_ready = ($urandom_range(0, 9) < 7);
            default: pixel_ready = 1'b0;
         endcase
         if (!readout_enable) begin
            req_idx    = 0;
            addr_valid = 1'b0;
         end
         if (ddr_rd_req) begin
            exp_addr = frame_off + AW'(req_idx);
            check("one_outstanding", 32'(pending), 0);
            check("req_not_full", 32'(fifo_level < DEPTH), 1);
            check("req_in_frame", 32'(req_idx < TOTAL), 1);
            check("ddr_addr", ddr_addr, exp_addr);
            if (req_idx < TOTAL) addr_log[req_idx] = ddr_addr;
            req_idx++;
            pending    = 1'b1;
            k          = 0;
            d          = (fixed_delay != 0) ? fixed_delay : 2 + $urandom_range(0, 3);
            lat_addr   = ddr_addr;
            last_addr  = ddr_addr;
            addr_valid = 1'b1;
         end else begin
            if (pending) k++;
            if (addr_valid && readout_enable) check("addr_hold", ddr_addr, last_addr);
         end
         if (pending && k >= d) begin
            pause     = 1'b0;
            data_read = memval(lat_addr);
            pending   = 1'b0;
         end else if (pending && k >= 2) begin
            pause     = 1'b1;
            data_read = $urandom;
         end else begin
            pause     = (fixed_delay != 0) ? 1'b0 : 1'($urandom_range(0, 1));
            data_read = $urandom;
         end
      end
   end

   // Frame-level compare: the stream must be word offset+i for pixel i, every cycle.
   initial begin
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         if (!model_on) begin
            out_idx = 0;
            sof_cnt = 0;
            eol_cnt = 0;
         end else begin
            a = frame_off + AW'(out_idx);
            check("valid_vs_level", 32'(pixel_valid), 32'(fifo_level != 0));
            check("level_bound", 32'(fifo_level <= DEPTH), 1);
            check("readout_done", 32'(readout_done), 32'(out_idx == TOTAL));
            if (pixel_valid) begin
               check("extra_pixel", 32'(out_idx < TOTAL), 1);
               check("pixel_data", pixel_data, conv(memval(a)));
               check("pixel_sof", 32'(pixel_sof), 32'(out_idx == 0));
               check("pixel_eol", 32'(pixel_eol), 32'(out_idx % W == W - 1));
               if (pixel_ready) begin
                  sof_cnt += int'(pixel_sof);
                  eol_cnt += int'(pixel_eol);
                  out_idx++;
               end
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_frame(input logic [AW-1:0] off, input int rmode, input int fdelay);
      tick();
      frame_off        = off;
      data_read_offset = off;
      ready_mode       = rmode;
      fixed_delay      = fdelay;
      model_on         = 1'b1;
      readout_enable   = 1'b1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 4000 && !readout_done; i++) begin
         tick();
         data_read_offset = AW'($urandom);
      end
      check("frame_done", 32'(readout_done), 1);
      repeat (3) tick();
      check("sof_count", sof_cnt, 1);
      check("eol_count", eol_cnt, H);
      check("req_count", req_idx, TOTAL);
   endtask

   task automatic end_frame();
      tick();
      readout_enable = 1'b0;
      model_on       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("done_cleared", 32'(readout_done), 0);
      check("idle_valid", 32'(pixel_valid), 0);
   endtask

   task automatic wait_first_valid();
      for (int i = 0; i < 200 && !pixel_valid; i++) @(negedge clk);
      check("first_valid_seen", 32'(pixel_valid), 1);
   endtask

   task automatic wait_accepted(input int n);
      for (int i = 0; i < 3000 && out_idx < n; i++) @(negedge clk);
      check("progress_reached", 32'(out_idx >= n), 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 32'(pixel_valid), 0);
      check({tag, "_data"}, pixel_data, 0);
      check({tag, "_sof"}, 32'(pixel_sof), 0);
      check({tag, "_eol"}, 32'(pixel_eol), 0);
      check({tag, "_level"}, fifo_level, 0);
      check({tag, "_done"}, 32'(readout_done), 0);
      check({tag, "_req"}, 32'(ddr_rd_req), 0);
      check({tag, "_addr"}, ddr_addr, 0);
   endtask

   initial begin
      logic [AW-1:0] off;
      reset_n          = 1'b0;
      readout_enable   = 1'b0;
      data_read_offset = '0;
      frame_off        = '0;
      model_on         = 1'b0;
      ready_mode       = 0;
      fixed_delay      = 2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      tick();
      reset_n = 1'b1;

      // Fixed latency, always-ready frame at 0x00100 with a known first word.
      start_frame(20'h00100, 0, 2);
      wait_first_valid();
`ifdef READOUT_GRAYSCALE_EN
      check("first_pixel", pixel_data, 32'h484848);
`else
      check("first_pixel", pixel_data, 32'hAA3311);
`endif
      check("first_sof", 32'(pixel_sof), 1);
      wait_done();
      check("first_addr", addr_log[0], 32'h00100);
      check("last_addr", addr_log[TOTAL-1], 32'h0015F);
      end_frame();

      // Random latency and random backpressure.
      start_frame(AW'($urandom), 1, 0);
      wait_done();
      end_frame();

      // Long stall mid-line: the FIFO must fill and the stream resume intact.
      start_frame(AW'($urandom), 0, 2);
      wait_accepted(20);
      tick();
      ready_mode = 2;
      repeat (50) tick();
      @(negedge clk);
      check("stall_level", fifo_level, DEPTH);
      check("stall_valid", 32'(pixel_valid), 1);
      ready_mode = 0;
      wait_done();
      end_frame();

      // Address wraps past the top of the address space.
      start_frame(20'hFFFF0, 1, 0);
      wait_done();
      check("wrap_addr15", addr_log[15], 32'hFFFFF);
      check("wrap_addr16", addr_log[16], 32'h00000);
      end_frame();

      // Abort while the read for pixel 50 is outstanding; the late data must be dropped.
      off = 20'h30000;
      start_frame(off, 0, 4);
      for (int i = 0; i < 3000 && req_idx < 51; i++) @(negedge clk);
      check("abort_point_reached", 32'(req_idx), 51);
      tick();
      readout_enable = 1'b0;
      model_on       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_valid", 32'(pixel_valid), 0);
      check("abort_level", fifo_level, 0);
      check("abort_done", 32'(readout_done), 0);
      repeat (10) tick();
      start_frame(off, 1, 0);
      for (int i = 0; i < 50 && !ddr_rd_req; i++) @(negedge clk);
      check("restart_addr", ddr_addr, 32'h30000);
      wait_first_valid();
      check("restart_sof", 32'(pixel_sof), 1);
      wait_done();
      end_frame();

      // One-cycle reset in the middle of a frame, then a clean frame.
      start_frame(AW'($urandom), 1, 0);
      wait_accepted(30);
      tick();
      reset_n        = 1'b0;
      readout_enable = 1'b0;
      model_on       = 1'b0;
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      check_zero_outputs("midreset");
      repeat (10) tick();
      start_frame(AW'($urandom), 1, 0);
      wait_done();
      end_frame();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
